// File: rtl/mcu_pkg.sv
// Shared definitions for the multi-cycle CPU memory-side datapath.
//  DW            bus/data width
//  DEFAULT_DEPTH default unified RAM depth in words
//  state_t       memory access FSM state (IDLE / RD_BUSY / WR_BUSY)
package mcu_pkg;

  localparam int unsigned DW            = 32;
  localparam int unsigned DEFAULT_DEPTH = 256;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_BUSY = 2'd1;
  localparam logic [1:0] WR_BUSY = 2'd2;

endpackage

// File: rtl/mem_bus_unit_if.sv
// Control/bus interface between the multi-cycle control unit and the memory stage.
//  master: control unit side (drives BusIn and the control strobes)
//  slave : memory stage side (drives BusOut/BusOe/Ready/ErrBusy)
interface mem_bus_unit_if
  import mcu_pkg::*;
#(
  parameter int unsigned DW = mcu_pkg::DW
);

  logic [DW-1:0] BusIn;
  logic          MARWr;
  logic          MemRd;
  logic          MemWr;
  logic          MDRSrc;
  logic          MDRWr;
  logic          MDROe;
  logic          MemOe;
  logic [DW-1:0] BusOut;
  logic          BusOe;
  logic          Ready;
  logic          ErrBusy;

  modport master (
    output BusIn, MARWr, MemRd, MemWr, MDRSrc, MDRWr, MDROe, MemOe,
    input  BusOut, BusOe, Ready, ErrBusy
  );

  modport slave (
    input  BusIn, MARWr, MemRd, MemWr, MDRSrc, MDRWr, MDROe, MemOe,
    output BusOut, BusOe, Ready, ErrBusy
  );

endinterface

// File: rtl/mem_bus_unit_mem_array.sv
// Unified instruction/data RAM: asynchronous read, synchronous write, no reset.
//  clk   in  write clock
//  we    in  write enable
//  addr  in  word index (shared by read and write)
//  wdata in  write data
//  rdata out read data at addr (combinational)
module mem_array
  import mcu_pkg::*;
#(
  parameter int unsigned DW    = mcu_pkg::DW,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_bus_unit.sv
// Memory-side datapath stage: MAR/MDR registers, unified RAM, bus read-back.
//  clk, rst   clock and asynchronous active-high reset
//  bus        slave side of mem_bus_unit_if (control strobes in, BusOut/BusOe/Ready/ErrBusy out)
//  MEM_LAT    0 = single-cycle RAM access; >0 = multi-cycle access with Ready handshake
module mem_bus_unit
  import mcu_pkg::*;
#(
  parameter int unsigned DW      = mcu_pkg::DW,
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned MEM_LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  mem_bus_unit_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mar, mdr, rd_buf, rd_data, mem_wdata, bus_mem;
  logic [AW-1:0] mar_idx, mem_addr;
  logic          mem_we, mdr_mem_ld, rdbuf_ld, err_set, ready, err;
  logic          unused_mar_bits;

  // Byte offset and bits above the RAM size are ignored, so addresses wrap.
  assign mar_idx         = mar[AW+1:2];
  assign unused_mar_bits = ^{mar[DW-1:AW+2], mar[1:0]};

  mem_array #(.DW(DW), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (rd_data)
  );

  if (MEM_LAT == 0) begin : g_lat0
    // Single-cycle access straight from MAR/MDR; a write colliding with a read is dropped.
    assign mem_addr   = mar_idx;
    assign mem_wdata  = mdr;
    assign mem_we     = bus.MemWr & ~bus.MemRd;
    assign mdr_mem_ld = bus.MDRWr & bus.MDRSrc;
    assign rdbuf_ld   = 1'b0;
    assign err_set    = bus.MemRd & bus.MemWr;
    assign ready      = 1'b1;
  end else begin : g_latn
    localparam int unsigned CW = $clog2(MEM_LAT + 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [AW-1:0] addr_q, addr_n;
    logic [DW-1:0] wdata_q, wdata_n;
    logic          ld_q, ld_n;

    // Access FSM state and the address/data captured at request time.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= IDLE;
        cnt     <= '0;
        addr_q  <= '0;
        wdata_q <= '0;
        ld_q    <= 1'b0;
      end else begin
        state   <= state_n;
        cnt     <= cnt_n;
        addr_q  <= addr_n;
        wdata_q <= wdata_n;
        ld_q    <= ld_n;
      end
    end

    // Next-state logic; the RAM is touched only in the last busy cycle.
    always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      addr_n     = addr_q;
      wdata_n    = wdata_q;
      ld_n       = ld_q;
      mem_we     = 1'b0;
      rdbuf_ld   = 1'b0;
      mdr_mem_ld = 1'b0;
      err_set    = bus.MemRd & bus.MemWr;
      case (state)
        IDLE: begin
          if (bus.MemRd) begin
            addr_n  = mar_idx;
            ld_n    = bus.MDRWr & bus.MDRSrc;
            cnt_n   = CW'(MEM_LAT - 1);
            state_n = RD_BUSY;
          end else if (bus.MemWr) begin
            addr_n  = mar_idx;
            wdata_n = mdr;
            cnt_n   = CW'(MEM_LAT - 1);
            state_n = WR_BUSY;
          end
        end
        RD_BUSY, WR_BUSY: begin
          err_set = bus.MemRd | bus.MemWr;
          if (cnt == '0) begin
            state_n = IDLE;
            if (state == RD_BUSY) begin
              rdbuf_ld   = 1'b1;
              mdr_mem_ld = ld_q;
            end else begin
              mem_we = 1'b1;
            end
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ready     = (state == IDLE);
  end

  // MAR/MDR/read buffer and the sticky protocol error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mar    <= '0;
      mdr    <= '0;
      rd_buf <= '0;
      err    <= 1'b0;
    end else begin
      if (bus.MARWr) mar <= bus.BusIn;
      if (mdr_mem_ld)                    mdr <= rd_data;
      else if (bus.MDRWr & ~bus.MDRSrc)  mdr <= bus.BusIn;
      if (rdbuf_ld) rd_buf <= rd_data;
      if (err_set)  err    <= 1'b1;
    end
  end

  // Bus drive: MDR has priority over the memory read path.
  assign bus_mem     = (MEM_LAT == 0) ? rd_data : rd_buf;
  assign bus.BusOe   = bus.MDROe | bus.MemOe;
  assign bus.BusOut  = bus.MDROe ? mdr : (bus.MemOe ? bus_mem : '0);
  assign bus.Ready   = ready;
  assign bus.ErrBusy = err;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Bench for mem_bus_unit: one single-cycle instance (d=0) and one MEM_LAT=2 instance (d=1).
module tb_mem_bus_unit;

  typedef struct packed {
    logic [31:0] bus_in;
    logic        marwr, memrd, memwr, mdrsrc, mdrwr, mdroe, memoe;
  } ctl_t;

  localparam logic [6:0] MARWR = 7'b1000000;
  localparam logic [6:0] MEMRD = 7'b0100000;
  localparam logic [6:0] MEMWR = 7'b0010000;
  localparam logic [6:0] MDRSRC = 7'b0001000;
  localparam logic [6:0] MDRWR = 7'b0000100;
  localparam logic [6:0] MDROE = 7'b0000010;
  localparam logic [6:0] MEMOE = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst [2];
  ctl_t        c [2];
  logic [31:0] o_out [2];
  logic        o_oe [2], o_rdy [2], o_err [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_bus_unit_if #(.DW(32)) bus0 ();
  mem_bus_unit_if #(.DW(32)) bus2 ();

  mem_bus_unit #(.DW(32), .DEPTH(256), .MEM_LAT(0)) u_lat0 (.clk(clk), .rst(rst[0]), .bus(bus0));
  mem_bus_unit #(.DW(32), .DEPTH(256), .MEM_LAT(2)) u_lat2 (.clk(clk), .rst(rst[1]), .bus(bus2));

  assign bus0.BusIn  = c[0].bus_in;  assign bus2.BusIn  = c[1].bus_in;
  assign bus0.MARWr  = c[0].marwr;   assign bus2.MARWr  = c[1].marwr;
  assign bus0.MemRd  = c[0].memrd;   assign bus2.MemRd  = c[1].memrd;
  assign bus0.MemWr  = c[0].memwr;   assign bus2.MemWr  = c[1].memwr;
  assign bus0.MDRSrc = c[0].mdrsrc;  assign bus2.MDRSrc = c[1].mdrsrc;
  assign bus0.MDRWr  = c[0].mdrwr;   assign bus2.MDRWr  = c[1].mdrwr;
  assign bus0.MDROe  = c[0].mdroe;   assign bus2.MDROe  = c[1].mdroe;
  assign bus0.MemOe  = c[0].memoe;   assign bus2.MemOe  = c[1].memoe;

  assign o_out[0] = bus0.BusOut;  assign o_out[1] = bus2.BusOut;
  assign o_oe[0]  = bus0.BusOe;   assign o_oe[1]  = bus2.BusOe;
  assign o_rdy[0] = bus0.Ready;   assign o_rdy[1] = bus2.Ready;
  assign o_err[0] = bus0.ErrBusy; assign o_err[1] = bus2.ErrBusy;

  // ---------------- behavioural model ----------------
  logic [31:0] m_mar [2], m_mdr [2], m_rdbuf [2], m_wd [2];
  bit          m_err [2], m_ld [2], m_rd [2];
  int          m_busy [2], m_addr [2];
  logic [31:0] m_mem [int];

  function automatic logic [31:0] mem_get(int key);
    if (m_mem.exists(key)) return m_mem[key];
    return 'x;
  endfunction

  function automatic int key_of(int d, logic [31:0] a);
    return d * 4096 + int'(a[9:2]);
  endfunction

  task automatic model_step(int d);
    ctl_t        k;
    logic [31:0] rd;
    int          key;
    bit          done_ld;
    if (rst[d]) begin
      m_mar[d] = 0; m_mdr[d] = 0; m_rdbuf[d] = 0; m_err[d] = 0; m_busy[d] = 0;
      return;
    end
    k       = c[d];
    key     = key_of(d, m_mar[d]);
    done_ld = 0;
    if (d == 0) begin
      rd = mem_get(key);
      if (k.memwr && !k.memrd) m_mem[key] = m_mdr[d];
      if (k.memrd && k.memwr) m_err[d] = 1;
      if (k.mdrwr) m_mdr[d] = k.mdrsrc ? rd : k.bus_in;
    end else begin
      if (m_busy[d] > 0) begin
        if (k.memrd || k.memwr) m_err[d] = 1;
        m_busy[d]--;
        if (m_busy[d] == 0) begin
          if (m_rd[d]) begin
            m_rdbuf[d] = mem_get(m_addr[d]);
            if (m_ld[d]) begin m_mdr[d] = m_rdbuf[d]; done_ld = 1; end
          end else begin
            m_mem[m_addr[d]] = m_wd[d];
          end
        end
      end else if (k.memrd) begin
        m_busy[d] = 2; m_rd[d] = 1; m_addr[d] = key; m_ld[d] = k.mdrwr && k.mdrsrc;
        if (k.memwr) m_err[d] = 1;
      end else if (k.memwr) begin
        m_busy[d] = 2; m_rd[d] = 0; m_addr[d] = key; m_wd[d] = m_mdr[d];
      end
      if (!done_ld && k.mdrwr && !k.mdrsrc) m_mdr[d] = k.bus_in;
    end
    if (k.marwr) m_mar[d] = k.bus_in;
  endtask

  always @(posedge clk or posedge rst[0]) model_step(0);
  always @(posedge clk or posedge rst[1]) model_step(1);

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  task automatic compare_dut(int d);
    ctl_t        k;
    logic [31:0] e_out;
    k = c[d];
    if (k.mdroe)      e_out = m_mdr[d];
    else if (k.memoe) e_out = (d == 0) ? mem_get(key_of(d, m_mar[d])) : m_rdbuf[d];
    else              e_out = 32'h0;
    if (!$isunknown(e_out)) check($sformatf("model d%0d BusOut", d), o_out[d], e_out);
    check($sformatf("model d%0d BusOe", d), 32'(o_oe[d]), 32'(k.mdroe | k.memoe));
    check($sformatf("model d%0d Ready", d), 32'(o_rdy[d]), (d == 0) ? 32'd1 : 32'(m_busy[d] == 0));
    check($sformatf("model d%0d ErrBusy", d), 32'(o_err[d]), 32'(m_err[d]));
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) compare_dut(d);
  end

  // ---------------- directed stimulus ----------------
  function automatic ctl_t mk(logic [31:0] bi, logic [6:0] f);
    return {bi, f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(int d, ctl_t k);
    c[d]     = k;
    c[1 - d] = '0;
  endtask

  task automatic cyc(int d, ctl_t k);
    apply(d, k);
    tick();
  endtask

  task automatic wait_ready(int d);
    int n;
    n = 0;
    apply(d, '0);
    while (o_rdy[d] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check($sformatf("d%0d ready timeout", d), 32'(o_rdy[d]), 32'd1);
  endtask

  initial begin
    rst[0] = 1'b1; rst[1] = 1'b1;
    c[0] = '0; c[1] = '0;
    repeat (2) tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset d%0d BusOe", d), 32'(o_oe[d]), 32'd0);
      check($sformatf("reset d%0d BusOut", d), o_out[d], 32'd0);
      check($sformatf("reset d%0d Ready", d), 32'(o_rdy[d]), 32'd1);
      check($sformatf("reset d%0d ErrBusy", d), 32'(o_err[d]), 32'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    tick();

    // Single-cycle write then instruction-fetch style read-back.
    cyc(0, mk(32'h10, MARWR));
    cyc(0, mk(32'hDEADBEEF, MDRWR));
    cyc(0, mk(32'h0, MEMWR));
    apply(0, mk(32'h0, MEMOE));
    @(negedge clk);
    check("lat0 fetch BusOut", o_out[0], 32'hDEADBEEF);
    check("lat0 fetch BusOe", 32'(o_oe[0]), 32'd1);
    tick();

    // MDR load from memory, then MDR priority over memory path.
    cyc(0, mk(32'h1234, MDRWR));
    cyc(0, mk(32'h0, MEMRD | MDRWR | MDRSRC));
    apply(0, mk(32'h0, MDROE));
    @(negedge clk);
    check("lat0 MDR from mem", o_out[0], 32'hDEADBEEF);
    tick();
    cyc(0, mk(32'h00001234, MDRWR));
    apply(0, mk(32'h0, MDROE | MEMOE));
    @(negedge clk);
    check("lat0 MDROe priority", o_out[0], 32'h00001234);
    tick();

    // Address wrap: 0x400 and 0x3 both map to word 0.
    cyc(0, mk(32'h400, MARWR));
    cyc(0, mk(32'h5, MDRWR));
    cyc(0, mk(32'h0, MEMWR));
    cyc(0, mk(32'h3, MARWR));
    apply(0, mk(32'h0, MEMOE));
    @(negedge clk);
    check("lat0 wrap read", o_out[0], 32'h5);
    tick();
    cyc(0, mk(32'h10, MARWR));
    apply(0, mk(32'h0, MEMOE));
    @(negedge clk);
    check("lat0 word4 intact", o_out[0], 32'hDEADBEEF);
    tick();

    // Read+write together: write of MDR=5 dropped, error flagged.
    cyc(0, mk(32'h0, MEMRD | MEMWR));
    apply(0, mk(32'h0, MEMOE));
    @(negedge clk);
    check("lat0 rdwr dropped", o_out[0], 32'hDEADBEEF);
    check("lat0 rdwr ErrBusy", 32'(o_err[0]), 32'd1);
    tick();

    // Mid-run reset of the single-cycle instance.
    apply(0, '0);
    rst[0] = 1'b1;
    @(negedge clk);
    check("rst0 ErrBusy", 32'(o_err[0]), 32'd0);
    check("rst0 Ready", 32'(o_rdy[0]), 32'd1);
    check("rst0 BusOe", 32'(o_oe[0]), 32'd0);
    tick();
    rst[0] = 1'b0;
    apply(0, mk(32'h0, MDROE));
    @(negedge clk);
    check("rst0 MDR zero", o_out[0], 32'h0);
    tick();
    apply(0, mk(32'h0, MEMOE));
    @(negedge clk);
    check("rst0 MAR zero reads word0", o_out[0], 32'h5);
    tick();

    // Latency-2 instance: preload two words.
    cyc(1, mk(32'h20, MARWR));
    cyc(1, mk(32'hA5A50001, MDRWR));
    cyc(1, mk(32'h0, MEMWR));
    wait_ready(1);
    cyc(1, mk(32'h24, MARWR));
    cyc(1, mk(32'h11112222, MDRWR));
    cyc(1, mk(32'h0, MEMWR));
    wait_ready(1);
    cyc(1, mk(32'h20, MARWR));

    // Read with MDR load at cycle n; write at n+1 must be ignored.
    apply(1, mk(32'h0, MEMRD | MDRWR | MDRSRC));
    @(negedge clk);
    check("lat2 n Ready", 32'(o_rdy[1]), 32'd1);
    tick();
    apply(1, mk(32'h0, MEMWR));
    @(negedge clk);
    check("lat2 n+1 Ready", 32'(o_rdy[1]), 32'd0);
    tick();
    apply(1, '0);
    @(negedge clk);
    check("lat2 n+2 Ready", 32'(o_rdy[1]), 32'd0);
    check("lat2 busy ErrBusy", 32'(o_err[1]), 32'd1);
    tick();
    apply(1, mk(32'h0, MDROE));
    @(negedge clk);
    check("lat2 n+3 Ready", 32'(o_rdy[1]), 32'd1);
    check("lat2 MDR loaded", o_out[1], 32'hA5A50001);
    tick();
    cyc(1, mk(32'h0, MEMRD));
    wait_ready(1);
    apply(1, mk(32'h0, MEMOE));
    @(negedge clk);
    check("lat2 RAM unchanged", o_out[1], 32'hA5A50001);
    tick();

    // Reset during RD_BUSY.
    cyc(1, mk(32'h24, MARWR));
    cyc(1, mk(32'h0, MEMRD));
    apply(1, '0);
    rst[1] = 1'b1;
    @(negedge clk);
    check("rst2 Ready", 32'(o_rdy[1]), 32'd1);
    check("rst2 BusOe", 32'(o_oe[1]), 32'd0);
    check("rst2 ErrBusy", 32'(o_err[1]), 32'd0);
    tick();
    rst[1] = 1'b0;
    apply(1, mk(32'h0, MDROE));
    @(negedge clk);
    check("rst2 MDR zero", o_out[1], 32'h0);
    tick();
    apply(1, mk(32'h0, MEMOE));
    @(negedge clk);
    check("rst2 RdBuf zero", o_out[1], 32'h0);
    tick();
    cyc(1, mk(32'h24, MARWR));
    cyc(1, mk(32'h0, MEMRD));
    wait_ready(1);
    apply(1, mk(32'h0, MEMOE));
    @(negedge clk);
    check("rst2 RAM preserved", o_out[1], 32'h11112222);
    tick();

    // Read+write together at latency 2.
    cyc(1, mk(32'h20, MARWR));
    cyc(1, mk(32'h0, MEMRD | MEMWR));
    wait_ready(1);
    apply(1, mk(32'h0, MEMOE));
    @(negedge clk);
    check("lat2 rdwr ErrBusy", 32'(o_err[1]), 32'd1);
    check("lat2 rdwr read done", o_out[1], 32'hA5A50001);
    tick();
    cyc(1, mk(32'h0, MEMRD));
    wait_ready(1);
    apply(1, mk(32'h0, MEMOE));
    @(negedge clk);
    check("lat2 rdwr write dropped", o_out[1], 32'hA5A50001);
    tick();

    apply(0, '0);
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
